// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : 8-digit common-anode seven-segment scan controller with
//               per-frame shadow registers, digit enable, blink and blanking.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYC    = 2000,
    parameter int BLINK_FRAMES = 62
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5*DIGITS-1:0]   digit_code,
    input  logic [DIGITS-1:0]     digit_en,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  scan_en,
    output logic [4:0]            num,
    output logic [DIGITS-1:0]     an_out,
    output logic                  frame_start
);

    localparam int c_DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int c_IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int c_BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST   = c_DIV_W'(SCAN_DIV - 1);
    localparam logic [c_DIV_W-1:0] c_BLANK      = c_DIV_W'(BLANK_CYC);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST   = c_IDX_W'(DIGITS - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST   = c_BLK_W'(BLINK_FRAMES - 1);
    localparam logic [4:0]         c_CODE_BLANK = 5'd31;

    logic [c_DIV_W-1:0]  r_div_cnt;
    logic [c_IDX_W-1:0]  r_idx;
    logic [c_BLK_W-1:0]  r_blink_cnt;
    logic                r_blink_phase;
    logic [5*DIGITS-1:0] r_code_sh;
    logic [DIGITS-1:0]   r_en_sh;
    logic [DIGITS-1:0]   r_blink_sh;
    logic                r_load_pend;

    logic                w_div_wrap;
    logic                w_frame_bnd;
    logic                w_load;
    logic                w_visible;
    logic [4:0]          w_codes [DIGITS];
    logic [DIGITS-1:0]   w_onehot;
    logic [4:0]          w_code_sel;

    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_digit
            assign w_codes[g]  = r_code_sh[5*g +: 5];
            assign w_onehot[g] = (r_idx == c_IDX_W'(g));
        end
    endgenerate

    assign w_code_sel  = w_codes[r_idx];
    assign w_div_wrap  = (r_div_cnt == c_DIV_LAST);
    assign w_frame_bnd = scan_en & w_div_wrap & (r_idx == c_IDX_LAST);
    // A pending load (after reset) is taken on the first enabled cycle; it
    // merges with a coincident frame boundary into a single load.
    assign w_load      = scan_en & (w_frame_bnd | r_load_pend);
    assign w_visible   = scan_en & r_en_sh[r_idx]
                       & ~(r_blink_sh[r_idx] & r_blink_phase)
                       & (r_div_cnt >= c_BLANK);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_idx     <= '0;
        end else if (scan_en) begin
            if (w_div_wrap) begin
                r_div_cnt <= '0;
                r_idx     <= (r_idx == c_IDX_LAST) ? '0 : r_idx + c_IDX_W'(1);
            end else begin
                r_div_cnt <= r_div_cnt + c_DIV_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_bnd) begin
            if (r_blink_cnt == c_BLK_LAST) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt   <= r_blink_cnt + c_BLK_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code_sh   <= {DIGITS{c_CODE_BLANK}};
            r_en_sh     <= '0;
            r_blink_sh  <= '0;
            r_load_pend <= 1'b1;
        end else if (w_load) begin
            r_code_sh   <= digit_code;
            r_en_sh     <= digit_en;
            r_blink_sh  <= blink_en;
            r_load_pend <= 1'b0;
        end
    end

    // Outputs lag the counter state by one cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            num         <= c_CODE_BLANK;
            an_out      <= '1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= w_load;
            if (w_visible) begin
                num    <= w_code_sel;
                an_out <= ~w_onehot;
            end else begin
                num    <= c_CODE_BLANK;
                an_out <= '1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Scoreboard bench for seg_scan_ctrl (SCAN_DIV=4, BLANK_CYC=1,
//               BLINK_FRAMES=2, DIGITS=8) with hand-derived output frames.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    typedef struct packed {
        logic [7:0] an;
        logic [4:0] num;
        logic       fs;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [39:0] digit_code;
    logic [7:0]  digit_en;
    logic [7:0]  blink_en;
    logic        scan_en;
    logic [4:0]  num;
    logic [7:0]  an_out;
    logic        frame_start;

    exp_t        exp_q [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    bit          mon_on = 1'b0;

    logic [39:0] codes0;
    logic [39:0] codes1;
    logic [39:0] codes2;

    seg_scan_ctrl #(
        .DIGITS       (8),
        .SCAN_DIV     (4),
        .BLANK_CYC    (1),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digit_code  (digit_code),
        .digit_en    (digit_en),
        .blink_en    (blink_en),
        .scan_en     (scan_en),
        .num         (num),
        .an_out      (an_out),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Interval n spans posedge n .. posedge n+1; inputs change 1 ns after
    // the edge and outputs are sampled on the falling edge.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic push_blank();
        exp_t e;
        e.an  = 8'hFF;
        e.num = 5'd31;
        e.fs  = 1'b0;
        exp_q.push_back(e);
    endtask

    // One output frame: each 4-cycle slot is 1 blank cycle then 3 cycles of
    // the digit (if enabled and not blinked off). Optional freeze gap of
    // blank cycles is inserted after entry frz_after.
    task automatic push_frame(input logic [39:0] codes, input logic [7:0] en,
                              input logic [7:0] hide, input bit fs0,
                              input bit fslast, input int frz_after,
                              input int frz_len, input int count);
        exp_t e;
        int   s;
        int   ph;
        bit   vis;
        for (int o = 0; o < count; o++) begin
            s     = o / 4;
            ph    = o % 4;
            vis   = (ph != 0) && en[s] && !hide[s];
            e.an  = vis ? ~(8'b1 << s) : 8'hFF;
            e.num = vis ? codes[5*s +: 5] : 5'd31;
            e.fs  = (o == 0 && fs0) || (o == 31 && fslast);
            exp_q.push_back(e);
            if (o == frz_after) begin
                for (int k = 0; k < frz_len; k++) push_blank();
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL underflow cyc=%0d got an=%h num=%0d fs=%b, expected nothing queued",
                         cyc, an_out, num, frame_start);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (an_out !== e.an || num !== e.num || frame_start !== e.fs) begin
                    errors++;
                    $display("FAIL out cyc=%0d got an=%h num=%0d fs=%b expected an=%h num=%0d fs=%b",
                             cyc, an_out, num, frame_start, e.an, e.num, e.fs);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 8; i++) codes0[5*i +: 5] = 5'(i);
        codes1          = codes0;
        codes1[10 +: 5] = 5'd16;
        codes1[30 +: 5] = 5'd22;
        codes2          = codes0;
        codes2[0 +: 5]  = 5'd29;
        codes2[5 +: 5]  = 5'd30;
        codes2[10 +: 5] = 5'd31;

        rst        = 1'b1;
        scan_en    = 1'b0;
        digit_code = codes0;
        digit_en   = 8'hFF;
        blink_en   = 8'h00;

        // Reset held over 3 edges, then idle with scan disabled.
        goto(3);
        rst = 1'b0;
        for (int k = 0; k < 11; k++) push_blank();
        mon_on = 1'b1;

        // Frame 0: initial load on the first enabled cycle.
        goto(13);
        scan_en = 1'b1;
        push_frame(codes0, 8'hFF, 8'h00, 1'b1, 1'b1, -1, 0, 32);

        // Change codes during digit-5 slot: digit 6 must still show 6.
        goto(34);
        digit_code = codes1;

        goto(45);
        push_frame(codes1, 8'hFF, 8'h00, 1'b0, 1'b1, -1, 0, 32);
        blink_en = 8'h01;

        // Frames 2-3: digit 0 blinked off.
        goto(77);
        push_frame(codes1, 8'hFF, 8'h01, 1'b0, 1'b1, -1, 0, 32);
        goto(109);
        push_frame(codes1, 8'hFF, 8'h01, 1'b0, 1'b1, -1, 0, 32);

        // Frame 4: blink phase back to visible.
        goto(141);
        push_frame(codes1, 8'hFF, 8'h00, 1'b0, 1'b1, -1, 0, 32);
        blink_en = 8'h00;

        // Frame 5: freeze for 10 cycles while digit 3 is mid-slot.
        goto(173);
        push_frame(codes1, 8'hFF, 8'h00, 1'b0, 1'b1, 14, 10, 32);
        digit_en = 8'h0F;
        goto(188);
        scan_en = 1'b0;
        goto(198);
        scan_en = 1'b1;

        // Frame 6: upper four digits disabled, frame length unchanged.
        goto(214);
        push_frame(codes1, 8'h0F, 8'h00, 1'b0, 1'b1, -1, 0, 32);

        // Frame 7 cut short by reset in the digit-2 slot.
        goto(246);
        push_frame(codes1, 8'h0F, 8'h00, 1'b0, 1'b0, -1, 0, 9);
        goto(256);
        rst        = 1'b1;
        digit_code = codes2;
        digit_en   = 8'hFF;
        push_blank();
        push_frame(codes2, 8'hFF, 8'h00, 1'b1, 1'b1, -1, 0, 32);
        goto(257);
        rst = 1'b0;

        goto(290);
        mon_on = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d entries left expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
